// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pairs queued fetch predictions with in-order execute resolutions,
// issuing BTB writes, mispredict flushes and saturating performance counters.
module branch_resolve_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    output logic                  pred_ready,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [ADDR_WIDTH-1:0] res_target,
    output logic                  btb_valid,
    output logic [ADDR_WIDTH-1:0] btb_update_pc,
    output logic [ADDR_WIDTH-1:0] btb_target_pc,
    output logic                  flush_valid,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  underflow_err,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc  [DEPTH];
    logic [ADDR_WIDTH-1:0] r_tgt [DEPTH];
    logic [DEPTH-1:0]      r_tk;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [PW:0]           r_count;

    logic                  w_run;
    logic                  w_push;
    logic                  w_res;
    logic                  w_mis;
    logic                  w_head_tk;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    logic [ADDR_WIDTH-1:0] w_head_tgt;

    assign w_run      = (r_state == RUN);
    assign pred_ready = w_run && (r_count != FULL);
    assign w_push     = pred_valid && pred_ready;
    assign w_res      = w_run && res_valid && (r_count != '0);
    assign w_head_pc  = r_pc[r_head];
    assign w_head_tgt = r_tgt[r_head];
    assign w_head_tk  = r_tk[r_head];
    assign w_mis      = w_res && ((w_head_tk != res_taken) || (res_taken && (w_head_tgt != res_target)));

    // Queue storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push && !w_mis) begin
            r_pc[r_tail]  <= pred_pc;
            r_tgt[r_tail] <= pred_target;
            r_tk[r_tail]  <= pred_taken;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= RUN;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            btb_valid      <= 1'b0;
            btb_update_pc  <= '0;
            btb_target_pc  <= '0;
            flush_valid    <= 1'b0;
            flush_pc       <= '0;
            underflow_err  <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            r_state     <= w_mis ? RECOVER : RUN;
            btb_valid   <= w_res && res_taken;
            flush_valid <= w_mis;
            if (w_res && res_taken) begin
                btb_update_pc <= w_head_pc;
                btb_target_pc <= res_target;
            end
            if (w_mis)
                flush_pc <= res_taken ? res_target : w_head_pc + ADDR_WIDTH'(4);
            if (w_run && res_valid && (r_count == '0))
                underflow_err <= 1'b1;
            if (w_res && (branch_cnt != '1))
                branch_cnt <= branch_cnt + 1'b1;
            if (w_mis && (mispredict_cnt != '1))
                mispredict_cnt <= mispredict_cnt + 1'b1;
            // A mispredict squashes every younger entry and any same-cycle enqueue.
            if (w_mis) begin
                r_head  <= r_head + 1'b1;
                r_tail  <= r_head + 1'b1;
                r_count <= '0;
            end else begin
                if (w_res)
                    r_head <= r_head + 1'b1;
                if (w_push)
                    r_tail <= r_tail + 1'b1;
                r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_res};
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table vectors, hand sequences and random traffic against a queue-based model.
module tb_branch_resolve_unit;
    localparam int AW = 32;
    localparam int D  = 8;
    localparam int CW = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst;
    logic          pred_valid, pred_ready, pred_taken;
    logic [AW-1:0] pred_pc, pred_target;
    logic          res_valid, res_taken;
    logic [AW-1:0] res_target;
    logic          btb_valid, flush_valid, underflow_err;
    logic [AW-1:0] btb_update_pc, btb_target_pc, flush_pc;
    logic [CW-1:0] branch_cnt, mispredict_cnt;

    branch_resolve_unit #(.ADDR_WIDTH(AW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .btb_valid(btb_valid), .btb_update_pc(btb_update_pc), .btb_target_pc(btb_target_pc),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .underflow_err(underflow_err),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic          t;
        logic [AW-1:0] tg;
    } ent_t;

    typedef struct {
        logic pv; logic [AW-1:0] ppc; logic pt; logic [AW-1:0] ptg;
        logic rv; logic rt; logic [AW-1:0] rtg;
        logic x_rdy; logic x_bv; logic [AW-1:0] x_upd; logic [AW-1:0] x_tgt;
        logic x_fv; logic [AW-1:0] x_fpc;
    } vec_t;

    ent_t          q[$];
    bit            m_rec, m_uf;
    int            m_bc, m_mc;
    logic          e_btbv, e_fv;
    logic [AW-1:0] e_upd, e_tgt, e_fpc;
    int            total = 0;
    int            bad = 0;
    vec_t          tbl[12];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic reset_model();
        q.delete();
        m_rec = 0; m_uf = 0; m_bc = 0; m_mc = 0;
    endtask

    // One clock: drive inputs, advance the model, then compare all outputs just after the edge.
    task automatic cycle(input logic pv, input logic [AW-1:0] ppc, input logic pt, input logic [AW-1:0] ptg,
                         input logic rv, input logic rt, input logic [AW-1:0] rtg);
        ent_t h;
        bit ready, push, res, mis;
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        ready = !m_rec && q.size() < D;
        push  = pv && ready;
        res   = !m_rec && rv && q.size() > 0;
        if (!m_rec && rv && q.size() == 0) m_uf = 1;
        e_btbv = 1'b0; e_fv = 1'b0; mis = 0;
        if (res) begin
            h = q.pop_front();
            if (m_bc < CMAX) m_bc++;
            e_btbv = rt; e_upd = h.pc; e_tgt = rtg;
            mis = (h.t != rt) || (rt && h.tg != rtg);
            e_fv = mis;
            e_fpc = rt ? rtg : h.pc + 32'd4;
            if (mis && m_mc < CMAX) m_mc++;
        end
        if (mis) q.delete();
        else if (push) begin
            h.pc = ppc; h.t = pt; h.tg = ptg;
            q.push_back(h);
        end
        m_rec = mis;
        @(posedge clk);
        #1;
        chk("pred_ready", 64'(pred_ready), 64'(!m_rec && q.size() < D));
        chk("btb_valid", 64'(btb_valid), 64'(e_btbv));
        if (e_btbv) begin
            chk("btb_update_pc", 64'(btb_update_pc), 64'(e_upd));
            chk("btb_target_pc", 64'(btb_target_pc), 64'(e_tgt));
        end
        chk("flush_valid", 64'(flush_valid), 64'(e_fv));
        if (e_fv) chk("flush_pc", 64'(flush_pc), 64'(e_fpc));
        chk("underflow_err", 64'(underflow_err), 64'(m_uf));
        chk("branch_cnt", 64'(branch_cnt), 64'(m_bc));
        chk("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mc));
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_reset_outputs(input string n);
        chk({n, "_ready"}, 64'(pred_ready), 64'd1);
        chk({n, "_btbv"}, 64'(btb_valid), 64'd0);
        chk({n, "_btbpc"}, 64'({btb_update_pc, btb_target_pc}), 64'd0);
        chk({n, "_fv"}, 64'(flush_valid), 64'd0);
        chk({n, "_fpc"}, 64'(flush_pc), 64'd0);
        chk({n, "_uf"}, 64'(underflow_err), 64'd0);
        chk({n, "_cnts"}, 64'({branch_cnt, mispredict_cnt}), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("after_reset");

        tbl[0]  = '{1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1, 32'h2000, 1'b1, 1'b1, 32'h1000, 32'h2000, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        tbl[4]  = '{1'b1, 32'h1100, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        tbl[5]  = '{1'b1, 32'h1200, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h1300, 1'b1, 32'h5000, 1'b1, 1'b1, 32'h4000, 1'b0, 1'b1, 32'h1000, 32'h4000, 1'b1, 32'h4000};
        tbl[7]  = '{1'b1, 32'h1400, 1'b1, 32'h0,    1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        tbl[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 32'h0};
        tbl[10] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        tbl[11] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].pv, tbl[i].ppc, tbl[i].pt, tbl[i].ptg, tbl[i].rv, tbl[i].rt, tbl[i].rtg);
            chk($sformatf("tbl%0d_ready", i), 64'(pred_ready), 64'(tbl[i].x_rdy));
            chk($sformatf("tbl%0d_btbv", i), 64'(btb_valid), 64'(tbl[i].x_bv));
            if (tbl[i].x_bv) begin
                chk($sformatf("tbl%0d_upd", i), 64'(btb_update_pc), 64'(tbl[i].x_upd));
                chk($sformatf("tbl%0d_tgt", i), 64'(btb_target_pc), 64'(tbl[i].x_tgt));
            end
            chk($sformatf("tbl%0d_fv", i), 64'(flush_valid), 64'(tbl[i].x_fv));
            if (tbl[i].x_fv) chk($sformatf("tbl%0d_fpc", i), 64'(flush_pc), 64'(tbl[i].x_fpc));
        end
        chk("tbl_underflow", 64'(underflow_err), 64'd1);
        chk("tbl_branch_cnt", 64'(branch_cnt), 64'd3);
        chk("tbl_mispredict_cnt", 64'(mispredict_cnt), 64'd2);

        // Mid-stream asynchronous reset while a flush pulse is live.
        cycle(1'b1, 32'h7000, 1'b1, 32'h7100, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h7200);
        chk("pre_reset_flush", 64'(flush_valid), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        reset_model();
        pred_valid = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Fill, observe no-bypass full condition, wrap the pointers and drain in order.
        for (int i = 0; i < D; i++)
            cycle(1'b1, 32'h3000 + 32'(i * 16), 1'(i % 2), 32'h3800 + 32'(i * 4), 1'b0, 1'b0, '0);
        chk("full_not_ready", 64'(pred_ready), 64'd0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h6000 + 32'(i * 16), 1'b1, 32'h6800 + 32'(i * 4), 1'(i < 3), q[0].t, q[0].tg);
        chk("wrap_count", 64'(q.size()), 64'(D));
        for (int i = 0; i < 2 * D && q.size() > 0; i++)
            cycle(1'b0, '0, 1'b0, '0, 1'b1, q[0].t, q[0].tg);
        chk("drained", 64'(q.size()), 64'd0);

        // Random traffic; counters are narrow so saturation is reached.
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] ppc, ptg, rtg;
            logic pv, pt, rv, rt;
            pv  = 1'($urandom_range(1, 0));
            ppc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            pt  = 1'($urandom_range(1, 0));
            ptg = 32'h100 * 32'($urandom_range(3, 0));
            rv  = ($urandom_range(2, 0) != 0);
            if (q.size() > 0 && $urandom_range(3, 0) != 0) begin
                rt = q[0].t; rtg = q[0].tg;
            end else begin
                rt = 1'($urandom_range(1, 0)); rtg = 32'h100 * 32'($urandom_range(3, 0));
            end
            cycle(pv, ppc, pt, ptg, rv, rt, rtg);
        end
        chk("branch_cnt_saturated", 64'(branch_cnt), 64'(CMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Writer end of the BTB update interface; produces the `update_pc` / `valid` / `target_pc` stream the BTB consumes.
- Holds fetch-side predictions in a small in-order queue and pairs each with its execute-stage resolution.
- Generates BTB insert/refresh writes and a one-cycle redirect (flush) on mispredict.
- Sits between fetch (BTB lookup side) and execute (branch resolution).

Parameters:
- ADDR_WIDTH, 32, width of all PCs and targets.
- DEPTH, 8, prediction queue entries; must be a power of 2, at least 2.
- CNT_WIDTH, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pred_valid  in  1  fetch presents a prediction for a branch.
- pred_ready  out  1  queue can accept; a transfer occurs when valid && ready.
- pred_pc  in  ADDR_WIDTH  PC of the branch.
- pred_taken  in  1  BTB prediction bit supplied with the lookup.
- pred_target  in  ADDR_WIDTH  BTB predicted_pc supplied with the lookup.
- res_valid  in  1  execute resolves the oldest outstanding branch, in program order.
- res_taken  in  1  actual direction.
- res_target  in  ADDR_WIDTH  actual taken target.
- btb_valid  out  1  BTB write strobe (drives BTB valid).
- btb_update_pc  out  ADDR_WIDTH  BTB write index PC.
- btb_target_pc  out  ADDR_WIDTH  BTB write target.
- flush_valid  out  1  single-cycle redirect pulse.
- flush_pc  out  ADDR_WIDTH  redirect PC.
- underflow_err  out  1  sticky; set when res_valid arrives with the queue empty.
- branch_cnt  out  CNT_WIDTH  resolved branches, saturating.
- mispredict_cnt  out  CNT_WIDTH  mispredicts, saturating.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs are 0, except pred_ready, which is 1.
  - Queue is empty; head and tail pointers are 0; FSM is in RUN.
- Queue:
  - Circular buffer with head/tail pointers of log2(DEPTH) bits that wrap at DEPTH, plus a count of log2(DEPTH)+1 bits.
  - Entry contents: {pc, taken, target}.
  - pred_ready = (state == RUN) && (count != DEPTH). No bypass: a full queue stays not-ready even in a cycle where the head dequeues.
- Resolution, in RUN, when res_valid and count > 0:
  - Dequeue the head entry and compare it with the resolution.
  - Mispredict = (head.taken != res_taken) || (res_taken && head.target != res_target).
  - Enqueue and dequeue in the same cycle leave count unchanged.
- BTB write:
  - Issued when res_taken is 1; not-taken branches are never written.
  - Registered, 1-cycle latency: next cycle btb_valid=1, btb_update_pc=head.pc, btb_target_pc=res_target.
  - btb_valid is otherwise 0.
- Flush:
  - On mispredict, the next cycle gives flush_valid=1 for exactly one cycle.
  - flush_pc = res_taken ? res_target : head.pc + 4, using modulo-2^ADDR_WIDTH add (wraps).
- FSM states:
  - RUN to RECOVER on mispredict.
  - RECOVER to RUN unconditionally after one cycle.
- In the mispredict cycle:
  - Every queued entry is discarded: count becomes 0 and tail is set to head+1, so head == tail.
  - A same-cycle pred handshake is dropped.
- In RECOVER:
  - pred_ready=0.
  - res_valid is ignored; it does not set the error flag and is not counted.
  - flush_valid and any BTB write from the mispredict are asserted during this cycle.
- Error case: res_valid with count == 0 in RUN sets underflow_err (cleared only by reset). The resolution is ignored: no BTB write, no flush, no counter change.
- Counters:
  - branch_cnt increments on each accepted resolution.
  - mispredict_cnt increments on each mispredict.
  - Both hold at all-ones.
- Reset asserted mid-operation returns every output to its reset value in the same cycle (asynchronous).

Test Plan:
- Reset then idle: after rst deasserts, pred_ready=1; btb_valid, flush_valid, branch_cnt and underflow_err are all 0.
- Correct taken prediction: enqueue pc=0x1000, taken=1, target=0x2000; resolve taken, 0x2000 -> next cycle btb_valid=1, update 0x1000 to 0x2000, flush_valid=0, branch_cnt=1.
- Target mispredict: enqueue pc=0x1000, taken=1, target=0x2000 plus two younger entries; resolve taken, 0x4000 -> BTB write 0x1000 to 0x4000; flush_valid=1 with flush_pc=0x4000; pred_ready=0 for one cycle; queue empty afterwards; mispredict_cnt=1.
- Direction mispredict at wrap: enqueue pc=0xFFFF_FFFC, taken=1; resolve not taken -> btb_valid=0, flush_pc=0x0000_0000.
- Full and wrap: enqueue DEPTH=8 entries -> pred_ready=0; resolve 3 correctly and enqueue 3 more -> pointers wrap; resolution order and values match enqueue order.
- Underflow: res_valid with the queue empty -> underflow_err=1, branch_cnt unchanged; apply rst low mid-stream -> all outputs return to reset values immediately.
